// File: rtl/regfile_bypass_sb.sv
// Two-write-port integer register file with write-to-read bypass and a
// per-register busy scoreboard for hazard stalls on in-flight producers.

module regfile_bypass_sb_rdport #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic [AW-1:0]              addr,
  input  logic [NREG-1:0][XLEN-1:0]  regs,
  input  logic [NREG-1:0]            busy,
  input  logic [1:0]                 we,
  input  logic [1:0][AW-1:0]         wa,
  input  logic [1:0][XLEN-1:0]       wd,
  input  logic [1:0]                 clr,
  output logic [XLEN-1:0]            data,
  output logic                       busy_out
);
  logic [1:0] hit;

  assign hit = {we[1] && (wa[1] == addr), we[0] && (wa[0] == addr)};

  // Port 1 is the younger result, so it takes bypass priority.
  always_comb begin
    data = regs[addr];
    if (addr == '0)  data = '0;
    else if (hit[1]) data = wd[1];
    else if (hit[0]) data = wd[0];
  end

  // A clearing write this cycle hides the stall so the consumer takes the bypass.
  assign busy_out = (addr != '0) && busy[addr] && !(|(hit & clr));
endmodule

module regfile_bypass_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG),
  parameter int NRD  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic [1:0]           wr_en,
  input  logic [2*AW-1:0]      wr_addr,
  input  logic [2*XLEN-1:0]    wr_data,
  input  logic [1:0]           wr_clr,
  input  logic                 sb_set,
  input  logic [AW-1:0]        sb_addr,
  input  logic                 flush,
  output logic [NREG-1:0]      busy_vec
);
  logic [NREG-1:0][XLEN-1:0] regs;
  logic [NREG-1:0]           busy, busy_nxt;
  logic [1:0]                we;
  logic [1:0][AW-1:0]        wa;
  logic [1:0][XLEN-1:0]      wd;

  // Writes are squashed while reset is held, including on the bypass path.
  assign we = wr_en & {2{rst}};
  assign wa = wr_addr;
  assign wd = wr_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs <= '0;
    end else begin
      for (int r = 1; r < NREG; r++)
        for (int p = 0; p < 2; p++)
          if (we[p] && (wa[p] == AW'(r))) regs[r] <= wd[p];
    end
  end

  // Priority: flush, then a new producer, then a clearing writeback.
  always_comb begin
    busy_nxt = busy;
    for (int b = 1; b < NREG; b++) begin
      if (flush)
        busy_nxt[b] = 1'b0;
      else if (sb_set && (sb_addr == AW'(b)))
        busy_nxt[b] = 1'b1;
      else if ((we[0] && wr_clr[0] && (wa[0] == AW'(b))) ||
               (we[1] && wr_clr[1] && (wa[1] == AW'(b))))
        busy_nxt[b] = 1'b0;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= busy_nxt;
  end

  assign busy_vec = busy;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    regfile_bypass_sb_rdport #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_rd (
      .addr     (rd_addr[k*AW +: AW]),
      .regs     (regs),
      .busy     (busy),
      .we       (we),
      .wa       (wa),
      .wd       (wd),
      .clr      (wr_clr),
      .data     (rd_data[k*XLEN +: XLEN]),
      .busy_out (rd_busy[k])
    );
  end
endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Directed bench for regfile_bypass_sb: default configuration via a vector
// table, plus hand sequences for reset and a 64-bit/16-entry/3-port variant.

module tb_regfile_bypass_sb;
  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // default instance: XLEN=32, NREG=32, NRD=2
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [1:0]  wr_clr;
  logic        sb_set;
  logic [4:0]  sb_addr;
  logic        flush;
  logic [31:0] busy_vec;

  regfile_bypass_sb u0 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_clr(wr_clr),
    .sb_set(sb_set), .sb_addr(sb_addr), .flush(flush), .busy_vec(busy_vec)
  );

  // wide instance: XLEN=64, NREG=16, NRD=3
  logic [11:0]  p_rd_addr;
  logic [191:0] p_rd_data;
  logic [2:0]   p_rd_busy;
  logic [1:0]   p_wr_en;
  logic [7:0]   p_wr_addr;
  logic [127:0] p_wr_data;
  logic [1:0]   p_wr_clr;
  logic         p_sb_set;
  logic [3:0]   p_sb_addr;
  logic         p_flush;
  logic [15:0]  p_busy_vec;

  regfile_bypass_sb #(.XLEN(64), .NREG(16), .NRD(3)) u1 (
    .clk(clk), .rst(rst), .rd_addr(p_rd_addr), .rd_data(p_rd_data), .rd_busy(p_rd_busy),
    .wr_en(p_wr_en), .wr_addr(p_wr_addr), .wr_data(p_wr_data), .wr_clr(p_wr_clr),
    .sb_set(p_sb_set), .sb_addr(p_sb_addr), .flush(p_flush), .busy_vec(p_busy_vec)
  );

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [1:0]  clr;
    logic        sb;
    logic [4:0]  sa;
    logic        fl;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] ed0;
    logic [31:0] ed1;
    logic [1:0]  eb;
    logic [31:0] ebv;
  } vec_t;

  vec_t vecs [16];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; wr_clr = '0;
    sb_set = 1'b0; sb_addr = '0; flush = 1'b0; rd_addr = '0;
  endtask

  initial begin
    vecs[0]  = '{2'b01, 5'd0, 32'h1234,     5'd0, 32'h0,        2'b00, 1'b0, 5'd0,  1'b0, 5'd0, 5'd5,  32'h0,        32'h0,        2'b00, 32'h0};
    vecs[1]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        2'b00, 1'b1, 5'd0,  1'b0, 5'd0, 5'd0,  32'h0,        32'h0,        2'b00, 32'h0};
    vecs[2]  = '{2'b11, 5'd7, 32'hAAAA0000, 5'd7, 32'h5555FFFF, 2'b00, 1'b0, 5'd0,  1'b0, 5'd7, 5'd7,  32'h5555FFFF, 32'h5555FFFF, 2'b00, 32'h0};
    vecs[3]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        2'b00, 1'b1, 5'd9,  1'b0, 5'd7, 5'd9,  32'h5555FFFF, 32'h0,        2'b00, 32'h0};
    vecs[4]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        2'b00, 1'b0, 5'd0,  1'b0, 5'd9, 5'd9,  32'h0,        32'h0,        2'b11, 32'h200};
    vecs[5]  = '{2'b10, 5'd0, 32'h0,        5'd9, 32'h42,       2'b10, 1'b0, 5'd0,  1'b0, 5'd9, 5'd9,  32'h42,       32'h42,       2'b00, 32'h200};
    vecs[6]  = '{2'b01, 5'd3, 32'h333,      5'd0, 32'h0,        2'b01, 1'b1, 5'd3,  1'b0, 5'd9, 5'd3,  32'h42,       32'h333,      2'b00, 32'h0};
    vecs[7]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        2'b00, 1'b1, 5'd1,  1'b0, 5'd3, 5'd0,  32'h333,      32'h0,        2'b01, 32'h8};
    vecs[8]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        2'b00, 1'b1, 5'd2,  1'b0, 5'd1, 5'd2,  32'h0,        32'h0,        2'b01, 32'hA};
    vecs[9]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        2'b00, 1'b1, 5'd31, 1'b0, 5'd2, 5'd31, 32'h0,        32'h0,        2'b01, 32'hE};
    vecs[10] = '{2'b01, 5'd2, 32'h7,        5'd0, 32'h0,        2'b00, 1'b1, 5'd4,  1'b1, 5'd2, 5'd31, 32'h7,        32'h0,        2'b11, 32'h8000000E};
    vecs[11] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        2'b00, 1'b0, 5'd0,  1'b0, 5'd2, 5'd4,  32'h7,        32'h0,        2'b00, 32'h0};
    vecs[12] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        2'b00, 1'b1, 5'd6,  1'b0, 5'd6, 5'd6,  32'h0,        32'h0,        2'b00, 32'h0};
    vecs[13] = '{2'b00, 5'd6, 32'hDEAD,     5'd6, 32'hBEEF,     2'b11, 1'b0, 5'd0,  1'b0, 5'd6, 5'd6,  32'h0,        32'h0,        2'b11, 32'h40};
    vecs[14] = '{2'b01, 5'd6, 32'h66,       5'd0, 32'h0,        2'b01, 1'b0, 5'd0,  1'b0, 5'd6, 5'd6,  32'h66,       32'h66,       2'b00, 32'h40};
    vecs[15] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        2'b00, 1'b0, 5'd0,  1'b0, 5'd6, 5'd0,  32'h66,       32'h0,        2'b00, 32'h0};

    idle();
    p_wr_en = '0; p_wr_addr = '0; p_wr_data = '0; p_wr_clr = '0;
    p_sb_set = 1'b0; p_sb_addr = '0; p_flush = 1'b0; p_rd_addr = '0;

    // reset held: write and sb_set on x5 must not take effect
    rst = 1'b0;
    @(negedge clk);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
    sb_set = 1'b1; sb_addr = 5'd5; rd_addr = {5'd5, 5'd5};
    #1;
    chk("rst_rd_x5_bypass", {32'h0, rd_data[31:0]}, 64'h0);
    chk("rst_busy_vec", {32'h0, busy_vec}, 64'h0);
    chk("rst_rd_busy", {62'h0, rd_busy}, 64'h0);
    @(negedge clk);
    chk("rst_rd_x5_after_edge", {32'h0, rd_data[31:0]}, 64'h0);
    chk("rst_busy_after_edge", {32'h0, busy_vec}, 64'h0);
    idle();
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      wr_en   = vecs[i].we;
      wr_addr = {vecs[i].wa1, vecs[i].wa0};
      wr_data = {vecs[i].wd1, vecs[i].wd0};
      wr_clr  = vecs[i].clr;
      sb_set  = vecs[i].sb;
      sb_addr = vecs[i].sa;
      flush   = vecs[i].fl;
      rd_addr = {vecs[i].ra1, vecs[i].ra0};
      #1;
      chk($sformatf("v%0d_rd_data0", i), {32'h0, rd_data[31:0]},  {32'h0, vecs[i].ed0});
      chk($sformatf("v%0d_rd_data1", i), {32'h0, rd_data[63:32]}, {32'h0, vecs[i].ed1});
      chk($sformatf("v%0d_rd_busy", i),  {62'h0, rd_busy},        {62'h0, vecs[i].eb});
      chk($sformatf("v%0d_busy_vec", i), {32'h0, busy_vec},       {32'h0, vecs[i].ebv});
    end

    // asynchronous reset mid-operation: state clears without an edge,
    // and the write and sb_set of that cycle are lost
    @(negedge clk);
    idle();
    sb_set = 1'b1; sb_addr = 5'd10;
    @(negedge clk);
    chk("pre_arst_busy_x10", {32'h0, busy_vec}, 64'h400);
    idle();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd11}; wr_data = {32'h0, 32'h99};
    sb_set = 1'b1; sb_addr = 5'd12; rd_addr = {5'd11, 5'd6};
    #2 rst = 1'b0;
    #1;
    chk("arst_busy_vec", {32'h0, busy_vec}, 64'h0);
    chk("arst_rd_x6", {32'h0, rd_data[31:0]}, 64'h0);
    chk("arst_rd_x11_bypass", {32'h0, rd_data[63:32]}, 64'h0);
    @(negedge clk);
    idle();
    rst = 1'b1;
    rd_addr = {5'd12, 5'd11};
    #1;
    chk("post_arst_rd_x11", {32'h0, rd_data[31:0]}, 64'h0);
    chk("post_arst_busy", {32'h0, busy_vec}, 64'h0);
    chk("post_arst_rd_busy", {62'h0, rd_busy}, 64'h0);

    // wide instance: three simultaneous reads, 4-bit addressing
    @(negedge clk);
    p_wr_en = 2'b11; p_wr_addr = {4'd3, 4'd15};
    p_wr_data = {64'hFEDCBA9876543210, 64'h0123456789ABCDEF};
    @(negedge clk);
    p_wr_en = 2'b01; p_wr_addr = {4'd0, 4'd8};
    p_wr_data = {64'h0, 64'h8888000000000008};
    @(negedge clk);
    p_wr_en = 2'b00; p_wr_addr = '0; p_wr_data = '0;
    p_rd_addr = {4'd8, 4'd3, 4'd15};
    #1;
    chk("wide_rd0_x15", p_rd_data[63:0],    64'h0123456789ABCDEF);
    chk("wide_rd1_x3",  p_rd_data[127:64],  64'hFEDCBA9876543210);
    chk("wide_rd2_x8",  p_rd_data[191:128], 64'h8888000000000008);
    p_rd_addr = {4'd8, 4'd15, 4'd0};
    #1;
    chk("wide_rd0_x0",  p_rd_data[63:0],    64'h0);
    chk("wide_rd1_x15", p_rd_data[127:64],  64'h0123456789ABCDEF);
    chk("wide_busy_vec", {48'h0, p_busy_vec}, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
